// File: rtl/gpu_axil_write_master.sv
// rtl/gpu_axil_write_master.sv - single-outstanding AXI-Lite write master with response timeout
module gpu_axil_write_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic [31:0] host_awaddr,
  output logic        host_awvalid,
  input  logic        host_awready,
  output logic [31:0] host_wdata,
  output logic        host_wvalid,
  input  logic        host_wready,
  input  logic [1:0]  host_bresp,
  input  logic        host_bvalid,
  output logic        host_bready,
  output logic        done_valid,
  output logic [1:0]  done_resp,
  output logic        done_timeout,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    WAIT_B = 2'd2
  } state_t;

  localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES);
  localparam logic        TO_EN    = (TIMEOUT_CYCLES != 0);

  state_t     state;
  state_t     state_next;
  logic       aw_done;
  logic       w_done;
  logic [7:0] to_cnt;
  logic [7:0] to_cnt_inc;
  logic       aw_fire;
  logic       w_fire;
  logic       aw_fin;
  logic       w_fin;
  logic       b_fire;
  logic       to_hit;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  assign aw_fire = host_awvalid && host_awready;
  assign w_fire  = host_wvalid && host_wready;
  assign aw_fin  = aw_done || aw_fire;
  assign w_fin   = w_done || w_fire;
  assign b_fire  = host_bvalid && host_bready;

  // The limit is compared against the post-increment count so the completion
  // lands exactly TIMEOUT_CYCLES cycles after bready rises.
  assign to_cnt_inc = (to_cnt == 8'hFF) ? to_cnt : to_cnt + 8'd1;
  assign to_hit     = TO_EN && (32'(to_cnt_inc) == TO_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cmd_valid) state_next = SEND;
      end
      SEND: begin
        if (aw_fin && w_fin) state_next = WAIT_B;
      end
      WAIT_B: begin
        if (b_fire || to_hit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_awaddr  <= '0;
      host_wdata   <= '0;
      host_awvalid <= 1'b0;
      host_wvalid  <= 1'b0;
      host_bready  <= 1'b0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      to_cnt       <= '0;
      done_valid   <= 1'b0;
      done_resp    <= 2'b00;
      done_timeout <= 1'b0;
    end else begin
      done_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            host_awaddr  <= cmd_addr;
            host_wdata   <= cmd_data;
            host_awvalid <= 1'b1;
            host_wvalid  <= 1'b1;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
          end
        end
        SEND: begin
          if (aw_fire) begin
            host_awvalid <= 1'b0;
            aw_done      <= 1'b1;
          end
          if (w_fire) begin
            host_wvalid <= 1'b0;
            w_done      <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            host_bready <= 1'b1;
            to_cnt      <= '0;
          end
        end
        WAIT_B: begin
          // A response arriving in the timeout cycle still reports its real code.
          if (b_fire) begin
            host_bready  <= 1'b0;
            done_valid   <= 1'b1;
            done_resp    <= host_bresp;
            done_timeout <= 1'b0;
          end else if (to_hit) begin
            host_bready  <= 1'b0;
            done_valid   <= 1'b1;
            done_resp    <= 2'b10;
            done_timeout <= 1'b1;
          end else begin
            to_cnt <= to_cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_axil_write_master.sv
// tb/tb_gpu_axil_write_master.sv - scoreboard bench for gpu_axil_write_master
module tb_gpu_axil_write_master;

  localparam int T = 6;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic [31:0] host_awaddr;
  logic        host_awvalid;
  logic        host_awready;
  logic [31:0] host_wdata;
  logic        host_wvalid;
  logic        host_wready;
  logic [1:0]  host_bresp;
  logic        host_bvalid;
  logic        host_bready;
  logic        done_valid;
  logic [1:0]  done_resp;
  logic        done_timeout;
  logic        busy;

  gpu_axil_write_master #(.TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_data     (cmd_data),
    .host_awaddr  (host_awaddr),
    .host_awvalid (host_awvalid),
    .host_awready (host_awready),
    .host_wdata   (host_wdata),
    .host_wvalid  (host_wvalid),
    .host_wready  (host_wready),
    .host_bresp   (host_bresp),
    .host_bvalid  (host_bvalid),
    .host_bready  (host_bready),
    .done_valid   (done_valid),
    .done_resp    (done_resp),
    .done_timeout (done_timeout),
    .busy         (busy)
  );

  typedef struct {
    logic [31:0] val;
    int          first;
    int          last;
  } beat_t;

  typedef struct {
    int          acc;
    int          br;
    int          done;
    logic [1:0]  resp;
    logic        to;
  } done_t;

  beat_t      exp_aw_q[$];
  beat_t      exp_w_q[$];
  done_t      exp_done_q[$];
  int         aw_dly_q[$];
  int         w_dly_q[$];
  int         b_dly_q[$];
  logic [1:0] b_rsp_q[$];

  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  int         prev_done = 0;
  logic [1:0] last_resp = 2'b00;
  logic       last_to = 1'b0;
  bit         b_noise = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: completion timing/outcome derived from the handshake delays alone.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input int da, input int dw,
                       input int db, input logic [1:0] br);
    int    start;
    int    acc;
    int    brise;
    done_t e;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_data  = d;
    start     = cyc;
    #1;
    for (int i = 0; i < 500 && !cmd_ready; i++) begin
      @(negedge clk);
      #1;
    end
    if (!cmd_ready) begin
      chk("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    acc = cyc;
    chk("accept_cycle", acc, (start > prev_done) ? start : prev_done);
    brise = acc + 2 + ((da > dw) ? da : dw);
    e.acc = acc;
    e.br  = brise;
    if (T != 0 && db >= T) begin
      e.resp = 2'b10;
      e.to   = 1'b1;
      e.done = brise + T;
    end else begin
      e.resp = br;
      e.to   = 1'b0;
      e.done = brise + db + 1;
    end
    prev_done = e.done;
    exp_done_q.push_back(e);
    exp_aw_q.push_back('{a, acc + 1, acc + 1 + da});
    exp_w_q.push_back('{d, acc + 1, acc + 1 + dw});
    aw_dly_q.push_back(da);
    w_dly_q.push_back(dw);
    b_dly_q.push_back(db);
    b_rsp_q.push_back(br);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && exp_done_q.size() != 0; i++) @(negedge clk);
    chk("drain", exp_done_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic flush();
    exp_aw_q.delete();
    exp_w_q.delete();
    exp_done_q.delete();
    aw_dly_q.delete();
    w_dly_q.delete();
    b_dly_q.delete();
    b_rsp_q.delete();
    prev_done = 0;
    last_resp = 2'b00;
    last_to   = 1'b0;
  endtask

  initial begin : aw_responder
    int cnt;
    int dly;
    bit act;
    host_awready = 1'b0;
    act = 1'b0;
    cnt = 0;
    dly = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || host_awready) begin
        host_awready = 1'b0;
        act = 1'b0;
      end else if (host_awvalid) begin
        if (!act) begin
          act = 1'b1;
          cnt = 0;
          dly = (aw_dly_q.size() != 0) ? aw_dly_q.pop_front() : 0;
        end
        if (cnt >= dly) host_awready = 1'b1;
        else cnt++;
      end
    end
  end

  initial begin : w_responder
    int cnt;
    int dly;
    bit act;
    host_wready = 1'b0;
    act = 1'b0;
    cnt = 0;
    dly = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || host_wready) begin
        host_wready = 1'b0;
        act = 1'b0;
      end else if (host_wvalid) begin
        if (!act) begin
          act = 1'b1;
          cnt = 0;
          dly = (w_dly_q.size() != 0) ? w_dly_q.pop_front() : 0;
        end
        if (cnt >= dly) host_wready = 1'b1;
        else cnt++;
      end
    end
  end

  // Outside WAIT_B the responder may drive junk on B to prove it is ignored.
  initial begin : b_responder
    int         cnt;
    int         dly;
    logic [1:0] rsp;
    bit         act;
    host_bvalid = 1'b0;
    host_bresp  = 2'b00;
    act = 1'b0;
    cnt = 0;
    dly = 0;
    rsp = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst_n || !host_bready) begin
        act = 1'b0;
        host_bvalid = (b_noise && rst_n) ? 1'($urandom) : 1'b0;
        host_bresp  = 2'($urandom);
      end else begin
        if (!act) begin
          act = 1'b1;
          cnt = 0;
          dly = (b_dly_q.size() != 0) ? b_dly_q.pop_front() : 0;
          rsp = (b_rsp_q.size() != 0) ? b_rsp_q.pop_front() : 2'b00;
        end
        if (cnt == dly) begin
          host_bvalid = 1'b1;
          host_bresp  = rsp;
        end else begin
          host_bvalid = 1'b0;
        end
        cnt++;
      end
    end
  end

  initial begin : monitor
    bit    aw_exp;
    bit    w_exp;
    bit    b_exp;
    bit    busy_exp;
    done_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        aw_exp = exp_aw_q.size() != 0 && cyc >= exp_aw_q[0].first && cyc <= exp_aw_q[0].last;
        chk("awvalid", 32'(host_awvalid), 32'(aw_exp));
        if (host_awvalid && aw_exp) chk("awaddr", host_awaddr, exp_aw_q[0].val);
        if (exp_aw_q.size() != 0 && cyc >= exp_aw_q[0].last) void'(exp_aw_q.pop_front());

        w_exp = exp_w_q.size() != 0 && cyc >= exp_w_q[0].first && cyc <= exp_w_q[0].last;
        chk("wvalid", 32'(host_wvalid), 32'(w_exp));
        if (host_wvalid && w_exp) chk("wdata", host_wdata, exp_w_q[0].val);
        if (exp_w_q.size() != 0 && cyc >= exp_w_q[0].last) void'(exp_w_q.pop_front());

        b_exp    = exp_done_q.size() != 0 && cyc >= exp_done_q[0].br && cyc < exp_done_q[0].done;
        busy_exp = exp_done_q.size() != 0 && cyc > exp_done_q[0].acc && cyc < exp_done_q[0].done;
        chk("bready", 32'(host_bready), 32'(b_exp));
        chk("busy", 32'(busy), 32'(busy_exp));

        if (done_valid) begin
          if (exp_done_q.size() == 0) begin
            chk("done_spurious", 32'(done_valid), 32'd0);
          end else begin
            e = exp_done_q.pop_front();
            chk("done_cycle", cyc, e.done);
            chk("done_resp", 32'(done_resp), 32'(e.resp));
            chk("done_timeout", 32'(done_timeout), 32'(e.to));
            chk("ready_at_done", 32'(cmd_ready), 32'd1);
            last_resp = e.resp;
            last_to   = e.to;
          end
        end else begin
          chk("resp_hold", 32'(done_resp), 32'(last_resp));
          chk("timeout_hold", 32'(done_timeout), 32'(last_to));
          if (exp_done_q.size() != 0 && cyc >= exp_done_q[0].done) begin
            chk("done_missing", cyc, 32'd0);
            void'(exp_done_q.pop_front());
          end
        end
      end
    end
  end

  initial begin : watchdog
    #(40000 * 10);
    errors++;
    checks++;
    $display("FAIL watchdog: got no end of run, expected completion within 40000 cycles");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : stimulus
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_data  = '0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_awvalid", 32'(host_awvalid), 32'd0);
    chk("rst_wvalid", 32'(host_wvalid), 32'd0);
    chk("rst_bready", 32'(host_bready), 32'd0);
    chk("rst_done_valid", 32'(done_valid), 32'd0);
    chk("rst_done_timeout", 32'(done_timeout), 32'd0);
    chk("rst_done_resp", 32'(done_resp), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_awaddr", host_awaddr, 32'd0);
    chk("rst_wdata", host_wdata, 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    issue(32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 0, 2'b00);
    wait_idle();
    issue(32'h0000_0020, 32'h1234_5678, 3, 0, 0, 2'b00);
    wait_idle();
    issue(32'h0000_0024, 32'hCAFE_F00D, 0, 2, 1, 2'b01);
    wait_idle();
    issue(32'h0000_0030, 32'h0BAD_0BAD, 0, 0, 5, 2'b11);
    wait_idle();
    issue(32'h0000_0034, 32'h5555_AAAA, 1, 1, T - 2, 2'b11);
    wait_idle();
    issue(32'h0000_0040, 32'hFFFF_0000, 0, 0, 255, 2'b00);
    wait_idle();

    issue(32'h0000_0050, 32'hA5A5_A5A5, 8, 0, 0, 2'b00);
    @(negedge clk);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_awvalid", 32'(host_awvalid), 32'd0);
    chk("midrst_wvalid", 32'(host_wvalid), 32'd0);
    chk("midrst_bready", 32'(host_bready), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done_valid", 32'(done_valid), 32'd0);
    flush();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    issue(32'h0000_0060, 32'h0F0F_0F0F, 0, 0, 0, 2'b00);
    wait_idle();

    issue(32'h0000_0070, 32'h1111_1111, 0, 0, 0, 2'b00);
    issue(32'h0000_0074, 32'h2222_2222, 0, 0, 0, 2'b01);
    wait_idle();

    b_noise = 1'b1;
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(2, 0)) @(negedge clk);
      issue($urandom, $urandom, int'($urandom_range(4, 0)), int'($urandom_range(4, 0)),
            int'($urandom_range(T + 2, 0)), 2'($urandom));
    end
    wait_idle();
    b_noise = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
